alu_nibble_sequencer: RTL and testbench
=======================================

ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the operand width in 4-bit nibbles (operand width W = 4*NIBBLES).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: operation request, sampled only when Ready=1.
REQ-005 SHALL have port OpA, input, W bits: operand A.
REQ-006 SHALL have port OpB, input, W bits: operand B.
REQ-007 SHALL have port Op, input, 4 bits: ALU function select.
REQ-008 SHALL have port M, input, 1 bit: mode (0 = arithmetic, 1 = logic).
REQ-009 SHALL have port CIN, input, 1 bit: initial carry into nibble 0.
REQ-010 SHALL have port Ready, output, 1 bit: idle and accepting Start.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port Result, output, W bits: assembled result.
REQ-013 SHALL have port Carry, output, 1 bit: final carry out.
REQ-014 SHALL have port Equal, output, 1 bit: AND of all per-nibble equality flags.
REQ-015 SHALL have port Zero, output, 1 bit: Result equals 0.
REQ-016 SHALL have port AluA, output, 4 bits: current A nibble to the 4-bit ALU slice.
REQ-017 SHALL have port AluB, output, 4 bits: current B nibble to the slice.
REQ-018 SHALL have port AluOp, output, 4 bits: latched Op to the slice.
REQ-019 SHALL have port AluM, output, 1 bit: latched M to the slice.
REQ-020 SHALL have port AluCin, output, 1 bit: carry into the slice.
REQ-021 SHALL have port AluOut, input, 4 bits: slice result, combinational in the same cycle.
REQ-022 SHALL have port AluCout, input, 1 bit: slice carry out.
REQ-023 SHALL have port AluEq, input, 1 bit: slice A=B flag.

Function
REQ-024 SHALL implement FSM states IDLE, RUN, DONE; Ready=1 only in IDLE.
REQ-025 SHALL, when Start=1 in IDLE, latch OpA, OpB, Op, M and CIN, clear the nibble index idx, set the equality accumulator to 1, and enter RUN.
REQ-026 SHALL in RUN drive AluA=A[4*idx+3:4*idx], AluB=B[4*idx+3:4*idx], AluCin=CIN for idx=0, else the carry registered from the previous nibble.
REQ-027 SHALL at each RUN edge write AluOut into Result nibble idx, register AluCout, AND AluEq into the equality accumulator, and increment idx.
REQ-028 SHALL transition RUN->DONE at the edge where idx=NIBBLES-1; Done=1 only in DONE; DONE->IDLE unconditionally after one cycle.
REQ-029 SHALL produce latency: Start accepted at edge t gives Done high in the cycle following edge t+NIBBLES; total NIBBLES+2 cycles from Start to Ready.
REQ-030 SHALL ignore Start in RUN and DONE, with no queueing.
REQ-031 SHALL present Carry as the last registered AluCout when M=0, and as 0 when M=1.
REQ-032 SHALL update Result, Carry, Equal and Zero only during RUN, and hold them stable from DONE until the next accepted Start.
REQ-033 SHALL hold AluA, AluB and AluCin at 0 outside RUN; AluOp and AluM SHALL show latched values.
REQ-034 SHALL compute Zero combinationally from Result.

Reset
REQ-035 SHALL on RST, at any time including mid-RUN, go to IDLE with idx=0 and Result, Carry, Equal, Zero-source registers, latched operands and AluOp/AluM all set to 0; Ready=1 and Done=0.
REQ-036 SHALL, when RST is deasserted with Start high, accept Start at the first subsequent rising edge.

Structure
REQ-037 SHALL place the state enum, the default NIBBLES and the opcode constants (OP_ADD=4'b1001, OP_XOR=4'b0110) in shared package alu_seq_pkg.
REQ-038 SHALL contain no sub-module; the 4-bit ALU slice is instantiated alongside this block by the parent.

Verification
REQ-039 SHALL cover: RST then OpA=16'h00FF, OpB=16'h0001, Op=OP_ADD, M=0, CIN=0 -> Result=16'h0100, Carry=0, Done at cycle 5.
REQ-040 SHALL cover: OpA=16'hFFFF, OpB=16'h0001 add -> Result=16'h0000, Zero=1, Carry=1.
REQ-041 SHALL cover: OpA=OpB=16'hA5A5, Op=OP_XOR, M=1 -> Result=0, Equal=1, Carry=0; then OpB=16'hA5A4 -> Equal=0.
REQ-042 SHALL cover: Start held high throughout -> operations back-to-back every 6 cycles; mid-RUN operand changes do not affect Result.
REQ-043 SHALL cover: RST asserted in the second RUN cycle -> immediately Ready=1 and Result=0; no Done pulse.
REQ-044 SHALL cover: the bench's slice model uses active-high carry, with add for OP_ADD/M=0 and XOR for OP_XOR/M=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: state encoding,
// default operand width in nibbles and the opcodes the bench exercises.
package alu_seq_pkg;

  localparam int NIBBLES_DEFAULT = 4;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Feeds a W-bit operation one nibble per cycle through an external 4-bit ALU
// slice, chaining the carry and folding the per-nibble equality flags.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [4*NIBBLES-1:0] OpA,
  input  logic [4*NIBBLES-1:0] OpB,
  input  logic [3:0]           Op,
  input  logic                 M,
  input  logic                 CIN,
  output logic                 Ready,
  output logic                 Done,
  output logic [4*NIBBLES-1:0] Result,
  output logic                 Carry,
  output logic                 Equal,
  output logic                 Zero,
  output logic [3:0]           AluA,
  output logic [3:0]           AluB,
  output logic [3:0]           AluOp,
  output logic                 AluM,
  output logic                 AluCin,
  input  logic [3:0]           AluOut,
  input  logic                 AluCout,
  input  logic                 AluEq
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  seq_state_t       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [3:0]       op_reg;
  logic             m_reg;
  logic             cin_reg;
  logic             carry_reg;
  logic             eq_reg;
  logic             ready_reg;
  logic             done_reg;
  logic [3:0]       a_nib [NIBBLES];
  logic [3:0]       b_nib [NIBBLES];
  logic [3:0]       res_nib_reg [NIBBLES];
  logic [W-1:0]     result_w;
  logic             run_w;

  assign run_w = (state_reg == RUN);

  // Each result nibble is its own register, written only on its own RUN step.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi]           = a_reg[4*gi +: 4];
    assign b_nib[gi]           = b_reg[4*gi +: 4];
    assign result_w[4*gi +: 4] = res_nib_reg[gi];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        res_nib_reg[gi] <= 4'h0;
      end else if (run_w && (idx_reg == IDX_W'(gi))) begin
        res_nib_reg[gi] <= AluOut;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 4'h0;
      m_reg     <= 1'b0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      eq_reg    <= 1'b0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            a_reg     <= OpA;
            b_reg     <= OpB;
            op_reg    <= Op;
            m_reg     <= M;
            cin_reg   <= CIN;
            idx_reg   <= '0;
            eq_reg    <= 1'b1;
            ready_reg <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          carry_reg <= AluCout;
          eq_reg    <= eq_reg & AluEq;
          if (idx_reg == LAST_IDX) begin
            idx_reg   <= '0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The first nibble takes the external carry; later nibbles chain the registered one.
  assign AluA   = run_w ? a_nib[idx_reg] : 4'h0;
  assign AluB   = run_w ? b_nib[idx_reg] : 4'h0;
  assign AluCin = run_w ? ((idx_reg == '0) ? cin_reg : carry_reg) : 1'b0;
  assign AluOp  = op_reg;
  assign AluM   = m_reg;

  assign Ready  = ready_reg;
  assign Done   = done_reg;
  assign Result = result_w;
  assign Carry  = carry_reg & ~m_reg;
  assign Equal  = eq_reg;
  assign Zero   = ~|result_w;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a 4-bit slice model, a whole-word reference
// model checked every cycle, and directed operations with literal expectations.
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [3:0]   op = 4'h0;
  logic         m = 1'b0;
  logic         cin = 1'b0;
  logic         ready, done, carry, equal, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_op, alu_out;
  logic         alu_m, alu_cin, alu_cout, alu_eq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .CLK(clk), .RST(rst), .Start(start), .OpA(opa), .OpB(opb), .Op(op),
    .M(m), .CIN(cin), .Ready(ready), .Done(done), .Result(result),
    .Carry(carry), .Equal(equal), .Zero(zero), .AluA(alu_a), .AluB(alu_b),
    .AluOp(alu_op), .AluM(alu_m), .AluCin(alu_cin), .AluOut(alu_out),
    .AluCout(alu_cout), .AluEq(alu_eq)
  );

  // 4-bit slice: active-high carry add, XOR in logic mode
  always_comb begin
    alu_out  = 4'h0;
    alu_cout = 1'b0;
    alu_eq   = (alu_a == alu_b);
    if (alu_op == OP_XOR && alu_m) begin
      alu_out = alu_a ^ alu_b;
    end else begin
      {alu_cout, alu_out} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-word reference: {equal, carry, result}
  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] o, input logic mm, input logic ci);
    logic [W:0] sum;
    if (o == OP_XOR && mm) return {(a == b), 1'b0, a ^ b};
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    return {(a == b), sum[W] & ~mm, sum[W-1:0]};
  endfunction

  // rem = cycles until Ready returns; Done expected when rem==1
  int           rem = 0;
  logic [W-1:0] exp_a = '0, exp_b = '0, exp_res = '0, held_res = '0;
  logic         exp_carry = 1'b0, exp_eq = 1'b0, exp_cin = 1'b0;
  logic         held_carry = 1'b0, held_eq = 1'b0, exp_m = 1'b0;
  logic [3:0]   exp_op = 4'h0;
  int           cmp_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= 0; held_res <= '0; held_carry <= 1'b0; held_eq <= 1'b0;
      exp_op <= 4'h0; exp_m <= 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        rem <= N + 1;
        exp_a <= opa; exp_b <= opb; exp_op <= op; exp_m <= m; exp_cin <= cin;
        {exp_eq, exp_carry, exp_res} <= calc(opa, opb, op, m, cin);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 1) begin
        held_res <= exp_res; held_carry <= exp_carry; held_eq <= exp_eq;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ready", ready, rem == 0);
      check("done", done, rem == 1);
      check("alu_op", alu_op, exp_op);
      check("alu_m", alu_m, exp_m);
      if (rem == 0) begin
        check("held_result", result, held_res);
        check("held_carry", carry, held_carry);
        check("held_equal", equal, held_eq);
        check("held_zero", zero, held_res == '0);
      end else if (rem == 1) begin
        check("done_result", result, exp_res);
        check("done_carry", carry, exp_carry);
        check("done_equal", equal, exp_eq);
        check("done_zero", zero, exp_res == '0);
      end else begin
        cmp_idx = N + 1 - rem;
        check("run_alu_a", alu_a, exp_a[4*cmp_idx +: 4]);
        check("run_alu_b", alu_b, exp_b[4*cmp_idx +: 4]);
        if (cmp_idx == 0) check("run_alu_cin0", alu_cin, exp_cin);
      end
      if (rem <= 1) begin
        check("idle_alu_a", alu_a, 0);
        check("idle_alu_b", alu_b, 0);
        check("idle_alu_cin", alu_cin, 0);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o,
                        input logic mm, input logic ci, output int cyc);
    opa = a; opb = b; op = o; m = mm; cin = ci; start = 1'b1; cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (done) begin
        cyc = i + 1;
        break;
      end
    end
    @(negedge clk);
  endtask

  int cyc;
  int n_done;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_carry", carry, 0);
    check("rst_equal", equal, 0);

    run_op(16'h00FF, 16'h0001, OP_ADD, 1'b0, 1'b0, cyc);
    check("add1_cycles", cyc, 5);
    check("add1_result", result, 16'h0100);
    check("add1_carry", carry, 0);
    check("add1_zero", zero, 0);

    run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0, cyc);
    check("add2_result", result, 16'h0000);
    check("add2_zero", zero, 1);
    check("add2_carry", carry, 1);

    run_op(16'h1234, 16'h4321, OP_ADD, 1'b0, 1'b1, cyc);
    check("add3_result", result, 16'h5556);

    run_op(16'hA5A5, 16'hA5A5, OP_XOR, 1'b1, 1'b0, cyc);
    check("xor1_result", result, 16'h0000);
    check("xor1_equal", equal, 1);
    check("xor1_carry", carry, 0);

    run_op(16'hA5A5, 16'hA5A4, OP_XOR, 1'b1, 1'b0, cyc);
    check("xor2_result", result, 16'h0001);
    check("xor2_equal", equal, 0);

    // Start held high: completions every 6 cycles, mid-RUN operand change
    opa = 16'h1234; opb = 16'h1111; op = OP_ADD; m = 1'b0; cin = 1'b0; start = 1'b1;
    n_done = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 2) begin
        opa = 16'h0F0F; opb = 16'h0101;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          check("b2b_first_at", i, 5);
          check("b2b_first_result", result, 16'h2345);
        end else if (n_done == 2) begin
          check("b2b_second_at", i, 11);
          check("b2b_second_result", result, 16'h1010);
        end else begin
          check("b2b_third_at", i, 17);
        end
      end
    end
    start = 1'b0;
    check("b2b_count", n_done, 3);
    @(negedge clk);

    // Reset in the second RUN cycle, then release with Start already high
    opa = 16'h0F0F; opb = 16'h0F0F; op = OP_ADD; m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    opa = 16'h3C3C; opb = 16'h3C00; op = OP_XOR; m = 1'b1; start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    #2 rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("accept_after_rst", ready, 0);
        start = 1'b0;
      end
      if (done) begin
        cyc = i + 1;
        break;
      end
    end
    check("post_rst_cycles", cyc, 5);
    check("post_rst_result", result, 16'h003C);
    check("post_rst_carry", carry, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
